hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Control end of the IF/ID pipeline-register interface. Generates the stall, flush and PC-write-enable signals that the IF/ID register and the PC consume, plus the ID/EX bubble.
- Detects load-use hazards, sequences multi-cycle (mul/div) stalls, and holds branch flushes for a programmable number of cycles.
- Sits in the ID stage beside the register file and control unit.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX. Legal range 2..16.
- FLUSH_CYCLES, 1, cycles Flush_IF_ID is held after a taken branch. Legal range 1..4.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_Rs  in  REG_ADDR_W  rs field of the instruction in ID.
- ID_Rt  in  REG_ADDR_W  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_Rt  in  REG_ADDR_W  destination register of the load in EX.
- ID_MultiCycle  in  1  the ID instruction is mul/div.
- Branch_Taken  in  1  branch resolved taken in ID this cycle.
- Stall_out  out  1  to IF/ID Stall_in; 1 = hold IF/ID.
- PCWrite  out  1  1 = PC may update.
- Flush_IF_ID  out  1  1 = IF/ID loads a NOP.
- Bubble_ID_EX  out  1  1 = zero ID/EX control bits.
- MC_Busy  out  1  multi-cycle sequence in progress.

Behaviour:
- The FSM state and down-counter (4-bit) are registered. All outputs are combinational from state plus current inputs (Mealy), so a stall takes effect in the same cycle the hazard is seen.
- Reset low asynchronously forces state=RUN and count=0, including mid-sequence. Output values with reset low: Stall_out=0, PCWrite=1, Flush_IF_ID=0, Bubble_ID_EX=0, MC_Busy=0.
- Load-use hazard (LU) = EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)).
- State RUN, evaluated in priority order:
  1. LU: Stall_out=1, PCWrite=0, Bubble_ID_EX=1. Branch_Taken and ID_MultiCycle are ignored this cycle. Stay in RUN; the hazard clears naturally next cycle, giving a one-cycle stall.
  2. Else Branch_Taken: Flush_IF_ID=1, PCWrite=1. If FLUSH_CYCLES>1, go to FLUSH with count=FLUSH_CYCLES-1. ID_MultiCycle is ignored.
  3. Else ID_MultiCycle: no stall this cycle; the op advances to EX. Go to MC_BUSY with count=MC_LATENCY-1.
  4. Else: all outputs idle (PCWrite=1).
- State MC_BUSY:
  - Outputs: Stall_out=1, PCWrite=0, Bubble_ID_EX=1, MC_Busy=1.
  - All hazard inputs are ignored.
  - Counter decrements each cycle; on the cycle count==1, go to RUN next edge.
  - Net effect: exactly MC_LATENCY-1 stall cycles.
- State FLUSH:
  - Outputs: Flush_IF_ID=1, PCWrite=1, Stall_out=0.
  - Inputs are ignored.
  - Counter decrements; at count==1, go to RUN.
- Illegal state encoding returns to RUN on the next edge.
- Stall_out and Flush_IF_ID are never both 1.
- Register 0 never causes a hazard.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: adds outputs StallCycles[31:0] and FlushCycles[31:0]. They count cycles with Stall_out=1 and with Flush_IF_ID=1 respectively, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package (pipeline_pkg): state enum RUN=2'd0, MC_BUSY=2'd1, FLUSH=2'd2; REG_ADDR_W default; ZERO_REG constant.
- One natural sub-module: hazard_load_use_cmp, the purely combinational LU comparator. It is reusable by the forwarding unit.

Test Plan:
- Reset low mid-MC_BUSY (count=2) -> outputs immediately idle: Stall_out=0, PCWrite=1, MC_Busy=0. After release, the state is RUN.
- EX_MemRead=1, EX_Rt=8, ID_Rs=8 -> Stall_out=1, PCWrite=0, Bubble_ID_EX=1 for one cycle. With EX_Rt=0 instead -> no stall.
- ID_MultiCycle=1 with MC_LATENCY=4 -> no stall in the issue cycle, then Stall_out=1 and MC_Busy=1 for exactly 3 cycles, then RUN.
- Branch_Taken=1 with FLUSH_CYCLES=2 -> Flush_IF_ID=1 for 2 consecutive cycles, PCWrite=1 throughout, Stall_out=0.
- LU and Branch_Taken in the same cycle -> stall only, Flush_IF_ID=0. Branch_Taken re-presented next cycle -> flush.
- With HAZ_STATS_EN: the LU, MC (latency 4) and flush (2) scenarios -> StallCycles=4, FlushCycles=2.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic.
//   state_e            : hazard controller FSM encoding (RUN/MC_BUSY/FLUSH)
//   REG_ADDR_W_DEFAULT : default register-specifier width
//   ZERO_REG           : architectural zero register index (never a hazard source)
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W_DEFAULT = 5;
  localparam int unsigned ZERO_REG           = 0;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMcBusy = 2'd1,
    StFlush  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Purely combinational load-use hazard comparator. Shared with the forwarding unit.
// Ports:
//   rs_i       : rs field of the consumer instruction
//   rt_i       : rt field of the consumer instruction
//   uses_rt_i  : consumer reads rt as a source
//   mem_read_i : producer is a load
//   ex_rt_i    : producer's destination register
//   hazard_o   : 1 = consumer must wait for the load
module hazard_load_use_cmp
  import pipeline_pkg::*;
#(
  parameter int unsigned AddrW = REG_ADDR_W_DEFAULT
) (
  input  logic [AddrW-1:0] rs_i,
  input  logic [AddrW-1:0] rt_i,
  input  logic             uses_rt_i,
  input  logic             mem_read_i,
  input  logic [AddrW-1:0] ex_rt_i,
  output logic             hazard_o
);

  localparam logic [AddrW-1:0] ZeroReg = AddrW'(ZERO_REG);

  always_comb begin
    hazard_o = mem_read_i && (ex_rt_i != ZeroReg) &&
               ((ex_rt_i == rs_i) || (uses_rt_i && (ex_rt_i == rt_i)));
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// IF/ID hazard stall controller: load-use stalls, multi-cycle (mul/div) stall sequencing
// and multi-cycle branch flushes. Outputs are Mealy (state + current inputs) so a stall
// acts in the cycle the hazard is seen.
// Ports:
//   Clk, Reset (async, active-low)
//   ID_Rs, ID_Rt, ID_UsesRt : source operands of the ID instruction
//   EX_MemRead, EX_Rt       : load in EX and its destination
//   ID_MultiCycle           : ID instruction is mul/div
//   Branch_Taken            : branch resolved taken in ID
//   Stall_out, PCWrite, Flush_IF_ID, Bubble_ID_EX, MC_Busy : control outputs
// Optional (macro HAZ_STATS_EN): StallCycles / FlushCycles saturating cycle counters.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int unsigned MC_LATENCY   = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_Rt,
  input  logic                  ID_MultiCycle,
  input  logic                  Branch_Taken,
  output logic                  Stall_out,
  output logic                  PCWrite,
  output logic                  Flush_IF_ID,
  output logic                  Bubble_ID_EX,
  output logic                  MC_Busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushCycles
`endif
);

  localparam logic [3:0] McLoad    = 4'(MC_LATENCY - 1);
  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       lu_hazard;

  hazard_load_use_cmp #(
    .AddrW (REG_ADDR_W)
  ) u_lu_cmp (
    .rs_i       (ID_Rs),
    .rt_i       (ID_Rt),
    .uses_rt_i  (ID_UsesRt),
    .mem_read_i (EX_MemRead),
    .ex_rt_i    (EX_Rt),
    .hazard_o   (lu_hazard)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRun;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    Stall_out    = 1'b0;
    PCWrite      = 1'b1;
    Flush_IF_ID  = 1'b0;
    Bubble_ID_EX = 1'b0;
    MC_Busy      = 1'b0;

    case (state_q)
      StRun: begin
        if (lu_hazard) begin
          // Load result arrives next cycle, so a single stall suffices.
          Stall_out    = 1'b1;
          PCWrite      = 1'b0;
          Bubble_ID_EX = 1'b1;
        end else if (Branch_Taken) begin
          Flush_IF_ID = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            count_d = FlushLoad;
          end
        end else if (ID_MultiCycle) begin
          // Issue cycle is not stalled; the op moves into EX now.
          state_d = StMcBusy;
          count_d = McLoad;
        end
      end
      StMcBusy: begin
        Stall_out    = 1'b1;
        PCWrite      = 1'b0;
        Bubble_ID_EX = 1'b1;
        MC_Busy      = 1'b1;
        count_d      = count_q - 4'd1;
        if (count_q <= 4'd1) begin
          state_d = StRun;
          count_d = 4'd0;
        end
      end
      StFlush: begin
        Flush_IF_ID = 1'b1;
        count_d     = count_q - 4'd1;
        if (count_q <= 4'd1) begin
          state_d = StRun;
          count_d = 4'd0;
        end
      end
      default: begin
        state_d = StRun;
        count_d = 4'd0;
      end
    endcase

    // Hold outputs idle while reset is asserted, whatever the operand inputs show.
    if (!Reset) begin
      Stall_out    = 1'b0;
      PCWrite      = 1'b1;
      Flush_IF_ID  = 1'b0;
      Bubble_ID_EX = 1'b0;
      MC_Busy      = 1'b0;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (Stall_out && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush_IF_ID && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, id_mc, br_taken;
  logic       stall, pc_write, flush, bubble, mc_busy;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(
    .REG_ADDR_W   (5),
    .MC_LATENCY   (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .Clk           (clk),
    .Reset         (rst_n),
    .ID_Rs         (id_rs),
    .ID_Rt         (id_rt),
    .ID_UsesRt     (id_uses_rt),
    .EX_MemRead    (ex_mem_read),
    .EX_Rt         (ex_rt),
    .ID_MultiCycle (id_mc),
    .Branch_Taken  (br_taken),
    .Stall_out     (stall),
    .PCWrite       (pc_write),
    .Flush_IF_ID   (flush),
    .Bubble_ID_EX  (bubble),
    .MC_Busy       (mc_busy)
`ifdef HAZ_STATS_EN
    ,
    .StallCycles   (stall_cycles),
    .FlushCycles   (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       mc;
    logic       br;
    logic       e_stall;
    logic       e_pcw;
    logic       e_flush;
    logic       e_bub;
    logic       e_busy;
  } vec_t;

  localparam int NumVec = 21;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic p, input logic f,
                         input logic b, input logic m);
    chk({tag, " stall"}, 32'(stall), 32'(s));
    chk({tag, " pcwrite"}, 32'(pc_write), 32'(p));
    chk({tag, " flush"}, 32'(flush), 32'(f));
    chk({tag, " bubble"}, 32'(bubble), 32'(b));
    chk({tag, " mc_busy"}, 32'(mc_busy), 32'(m));
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] er, input logic mc, input logic br);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr; ex_rt = er;
    id_mc = mc; br_taken = br;
  endtask

  // Advance to the next active edge, then step just past it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rs rt  u  mr er  mc br   st pw fl bu mb
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset with a load-use pattern present: outputs must still be idle.
    rst_n = 1'b0;
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
    #3;
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Cycle-by-cycle table: each row is one cycle, expectations include FSM history.
    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read, vecs[i].ex_rt,
            vecs[i].mc, vecs[i].br);
      @(negedge clk);
      chk_out($sformatf("row%0d", i), vecs[i].e_stall, vecs[i].e_pcw, vecs[i].e_flush,
              vecs[i].e_bub, vecs[i].e_busy);
      next_cycle();
    end
`ifdef HAZ_STATS_EN
    chk("table stall_cycles", stall_cycles, 32'd7);
    chk("table flush_cycles", flush_cycles, 32'd4);
`endif

    // Reset asserted mid-MC_BUSY with count=2.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("mc_pre_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("mid_mc_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef HAZ_STATS_EN
    chk("reset stall_cycles", stall_cycles, 32'd0);
    chk("reset flush_cycles", flush_cycles, 32'd0);
`endif
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk_out("post_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    // A flush can only appear from RUN, proving the sequence was abandoned.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("post_reset_branch", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("post_reset_flush2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Stats scenario from a fresh reset: LU (1) + MC latency 4 (3) + flush (2).
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    next_cycle();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    next_cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) next_cycle();
    @(negedge clk);
    chk_out("mc_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    next_cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
`ifdef HAZ_STATS_EN
    chk("scenario stall_cycles", stall_cycles, 32'd4);
    chk("scenario flush_cycles", flush_cycles, 32'd2);
`endif
    @(negedge clk);
    chk_out("final_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
